// File: rtl/nco_i2c_pkg.sv
// rtl/nco_i2c_pkg.sv - shared constants, state encoding and frame helpers for the NCO I2C link
package nco_i2c_pkg;

    localparam logic [7:0] NCO_I2C_ADDR = 8'hEA;
    localparam logic [1:0] SEL_FREQ     = 2'b10;
    localparam logic [1:0] SEL_DUTY     = 2'b01;
    localparam int         FREQ_W       = 64;
    localparam int         DUTY_W       = 16;
    localparam int         SHIFT_W      = 8 + FREQ_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_AACK  = 3'd3,
        ST_DATA  = 3'd4,
        ST_DACK  = 3'd5,
        ST_STOP  = 3'd6
    } i2c_state_t;

    // Number of payload bits that follow the control byte.
    function automatic logic [6:0] payload_bits(input logic [1:0] sel);
        logic [6:0] n;
        case (sel)
            SEL_FREQ: n = 7'(FREQ_W);
            SEL_DUTY: n = 7'(DUTY_W);
            default:  n = 7'd0;
        endcase
        return n;
    endfunction

    // Control byte followed by the selected payload, MSB-aligned.
    function automatic logic [SHIFT_W-1:0] pack_frame(input logic [7:0] ctrl,
                                                      input logic [FREQ_W-1:0] freq,
                                                      input logic [DUTY_W-1:0] duty);
        logic [FREQ_W-1:0] pay;
        case (ctrl[4:3])
            SEL_FREQ: pay = freq;
            SEL_DUTY: pay = {duty, {(FREQ_W-DUTY_W){1'b0}}};
            default:  pay = '0;
        endcase
        return {ctrl, pay};
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// rtl/i2c_quarter_tick.sv - SCL quarter-period down-counter with restartable quarter index
module i2c_quarter_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_restart,
    output logic       o_tick,
    output logic [1:0] o_quarter
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;
    logic [1:0] r_quarter;

    // Count down each quarter; restart realigns to the start of quarter 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= RELOAD;
            r_quarter <= 2'd0;
        end else if (i_restart) begin
            r_cnt     <= RELOAD;
            r_quarter <= 2'd0;
        end else if (r_cnt == 8'd0) begin
            r_cnt     <= RELOAD;
            r_quarter <= r_quarter + 2'd1;
        end else begin
            r_cnt     <= r_cnt - 8'd1;
        end
    end

    // Tick marks the last clk of the current quarter.
    assign o_tick    = (r_cnt == 8'd0);
    assign o_quarter = r_quarter;

endmodule

// File: rtl/i2c_nco_master.sv
// rtl/i2c_nco_master.sv - serialises one NCO configuration command as an I2C write
module i2c_nco_master
    import nco_i2c_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter logic [7:0] SLAVE_ADDR = NCO_I2C_ADDR
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_ctrl,
    input  logic [63:0] cmd_freq,
    input  logic [15:0] cmd_duty,
    output logic        scl,
    inout  wire         sda,
    output logic        busy,
    output logic        done,
    output logic        ack_error
);

    i2c_state_t          r_state;
    logic [SHIFT_W-1:0]  r_shift;
    logic [6:0]          r_bit;
    logic                r_scl;
    logic                r_sda_oe;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_ack_error;
    logic                r_nack;

    logic                w_tick;
    logic [1:0]          w_quarter;
    logic                w_accept;
    logic                w_restart;
    logic                w_sda_in;
    logic [2:0]          w_addr_idx;

    assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
    // START is only two quarters long, so ADDR needs the quarter index realigned.
    assign w_restart  = w_accept || ((r_state == ST_START) && w_tick && (w_quarter == 2'd1));
    assign w_sda_in   = sda;
    assign w_addr_idx = r_bit[2:0] - 3'd1;

    i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_restart (w_restart),
        .o_tick    (w_tick),
        .o_quarter (w_quarter)
    );

    // Frame sequencer; bus outputs are set for the quarter that begins next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit       <= 7'd0;
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_state     <= ST_START;
                        r_shift     <= pack_frame(cmd_ctrl, cmd_freq, cmd_duty);
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_ack_error <= 1'b0;
                        r_nack      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        if (w_quarter == 2'd0) begin
                            r_sda_oe <= 1'b1;
                        end else begin
                            r_state  <= ST_ADDR;
                            r_bit    <= 7'd7;
                            r_scl    <= 1'b0;
                            r_sda_oe <= ~SLAVE_ADDR[7];
                        end
                    end
                end
                ST_ADDR: begin
                    if (w_tick) begin
                        if (w_quarter == 2'd1) begin
                            r_scl <= 1'b1;
                        end else if (w_quarter == 2'd3) begin
                            r_scl <= 1'b0;
                            if (r_bit == 7'd0) begin
                                r_state  <= ST_AACK;
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_bit    <= r_bit - 7'd1;
                                r_sda_oe <= ~SLAVE_ADDR[w_addr_idx];
                            end
                        end
                    end
                end
                ST_AACK, ST_DACK: begin
                    if (w_tick) begin
                        if (w_quarter == 2'd1) begin
                            r_scl <= 1'b1;
                        end else if (w_quarter == 2'd2) begin
                            if (w_sda_in) begin
                                r_ack_error <= 1'b1;
                                r_nack      <= (r_state == ST_AACK);
                            end
                        end else if (w_quarter == 2'd3) begin
                            r_scl <= 1'b0;
                            if ((r_state == ST_DACK) || r_nack) begin
                                r_state  <= ST_STOP;
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_state  <= ST_DATA;
                                r_bit    <= 7'd7 + payload_bits(r_shift[SHIFT_W-4:SHIFT_W-5]);
                                r_sda_oe <= ~r_shift[SHIFT_W-1];
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (w_quarter == 2'd1) begin
                            r_scl <= 1'b1;
                        end else if (w_quarter == 2'd3) begin
                            r_scl <= 1'b0;
                            if (r_bit == 7'd0) begin
                                r_state  <= ST_DACK;
                                r_sda_oe <= 1'b0;
                            end else begin
                                r_bit    <= r_bit - 7'd1;
                                r_shift  <= {r_shift[SHIFT_W-2:0], 1'b0};
                                r_sda_oe <= ~r_shift[SHIFT_W-2];
                            end
                        end
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        if (w_quarter == 2'd0) begin
                            r_scl <= 1'b1;
                        end else if (w_quarter == 2'd1) begin
                            r_sda_oe <= 1'b0;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cmd_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign sda       = r_sda_oe ? 1'b0 : 1'bz;
    assign scl       = r_scl;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign ack_error = r_ack_error;

endmodule
